scie_pipelined: RTL and testbench
=================================

# scie_pipelined

Custom-instruction accelerator attached to the core's SCIE (Simple Custom Instruction Extension) port. It implements a 5-tap FIR filter driven by three custom opcodes:
- load a coefficient;
- push a sample into the delay line;
- read the filter output.

The result is returned through a registered `io_rd` with one-cycle latency.

## Interface
Parameters:
- `NTAPS`, 5, number of filter taps (coefficients and delay-line entries).
- `XLEN`, 32, datapath width of operands, coefficients, samples and result.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_valid`  in  1  high for one cycle per issued instruction.
- `io_insn`  in  32  instruction word; only bits [6:0] (opcode) are decoded.
- `io_rs1`  in  XLEN  first source operand.
- `io_rs2`  in  XLEN  second source operand.
- `io_rd`  out  XLEN  registered result.

## Operation
State:
- `coef[0..NTAPS-1]`, XLEN bits each.
- `x[0..NTAPS-1]`, the delay line; `x[0]` is the newest sample.
- `rd_q`, which drives `io_rd`.

Decode when `io_valid`=1, using `io_insn[6:0]`:
- 0x0B (custom-0, SETCOEF): `coef[io_rs2] <= io_rs1`.
  - If `io_rs2` >= NTAPS, the write is ignored.
  - All upper bits of `io_rs2` participate in this comparison.
- 0x2B (custom-1, PUSH): `x[0] <= io_rs1` and `x[i] <= x[i-1]` for i=1..NTAPS-1. The oldest sample is discarded.
- 0x5B (custom-2, READ): `rd_q <= sum over i of coef[i]*x[i]`.
  - Each product and the sum are truncated modulo 2^XLEN (unsigned wrap).
  - Signed interpretation yields the same low bits.
- Any other opcode: no state change.

When `io_valid`=0, no state changes and `rd_q` holds.

Only one instruction is accepted per cycle. There is no stall or busy signal; every valid instruction is accepted.

Reset:
- All `coef`, all `x` and `rd_q` are cleared to 0.
- `io_rd` reads 0 in the cycle after reset is sampled high.
- Reset takes priority over any simultaneous valid instruction.

## Timing
- SETCOEF and PUSH take effect at the rising edge where `io_valid`=1. A subsequent instruction in the very next cycle sees the updated state.
- READ latency is 1 cycle:
  - `io_rd` reflects the sum computed from state as it was before the READ edge.
  - The value appears immediately after that edge and holds until the next READ or reset.
- The READ sum uses registered state only, with no same-cycle bypass. Because only one instruction issues per cycle, a PUSH followed by READ in the next cycle includes the pushed sample.
- Combinational multiply-accumulate path: NTAPS XLEN×XLEN products plus an adder tree, feeding `rd_q`. Pipelining inside the MAC is not permitted; the 1-cycle READ latency is fixed.
- Reset asserted mid-sequence clears all state at that edge. The next READ returns 0 until coefficients and samples are reloaded.

## Test plan
- **Reset:** hold `reset` for 5 cycles → `io_rd`=0. After reset, READ (insn=0x5B) → `io_rd`=0.
- **Filter sequence:**
  - Load coefficients with insn=0x0B, (`io_rs1`,`io_rs2`) = (5,0), (99,1), (47,2), (41,3), (25,4).
  - Then repeat PUSH x, one idle cycle, READ, for x = 90, 64, 93, 1, 97.
  - Required `io_rd` one cycle after each READ: 450, 9230, 11031, 15910, 9829.
- **Out-of-range index:** SETCOEF with `io_rs2`=5 and `io_rs1`=1000 → no coefficient changes. A following PUSH/READ gives results identical to the filter-sequence scenario.
- **Valid gating:**
  - Present PUSH and READ encodings with `io_valid`=0 → delay line unchanged and `io_rd` holds its previous value.
  - An unknown opcode (e.g. 0x7B) with `io_valid`=1 → no state change.
- **Wrap-around:** set `coef[0]`=0xFFFFFFFF, other coefficients 0; PUSH 2; READ → `io_rd`=0xFFFFFFFE.
- **Back-to-back and reset interaction:**
  - PUSH immediately followed by READ in the next cycle → the sum includes the new sample.
  - Assert `reset` for one cycle after the filter sequence, then READ → `io_rd`=0.

Source files
------------

// File: rtl/scie_pipelined.sv
// SCIE custom-instruction accelerator: 5-tap FIR with SETCOEF / PUSH / READ opcodes.
// The READ path is a single combinational MAC feeding the registered result.
module scie_pipelined #(
  parameter int NTAPS = 5,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;

  logic [XLEN-1:0] coef_p0 [NTAPS];
  logic [XLEN-1:0] x_p0    [NTAPS];
  logic [XLEN-1:0] rd_p1;
  logic [6:0]      opcode;
  logic            insn_unused;

  assign opcode      = io_insn[6:0];
  assign insn_unused = &{1'b0, io_insn[31:7]};

  // Products and the running sum wrap modulo 2^XLEN, so the low bits are
  // identical whether the operands are read as signed or unsigned.
  function automatic logic [XLEN-1:0] mac_wrap(
    input logic [XLEN-1:0] c [NTAPS],
    input logic [XLEN-1:0] s [NTAPS]
  );
    logic [XLEN-1:0] acc;
    acc = '0;
    for (int i = 0; i < NTAPS; i++) begin
      acc = acc + c[i] * s[i];
    end
    return acc;
  endfunction

  // Stage p0 -> p1: instruction decode, state update and READ result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_p0[i] <= '0;
        x_p0[i]    <= '0;
      end
      rd_p1 <= '0;
    end else if (io_valid) begin
      case (opcode)
        OP_SETCOEF: begin
          // Full-width compare: any index >= NTAPS matches no tap and is dropped.
          for (int i = 0; i < NTAPS; i++) begin
            if (io_rs2 == XLEN'(i)) coef_p0[i] <= io_rs1;
          end
        end
        OP_PUSH: begin
          x_p0[0] <= io_rs1;
          for (int i = 1; i < NTAPS; i++) begin
            x_p0[i] <= x_p0[i-1];
          end
        end
        OP_READ: rd_p1 <= mac_wrap(coef_p0, x_p0);
        default: ;
      endcase
    end
  end

  assign io_rd = rd_p1;

endmodule

// File: tb/tb_scie_pipelined.sv
// Self-checking bench for scie_pipelined: vector table, directed corner cases,
// and randomized traffic compared against an abstract FIR model.
module tb_scie_pipelined;

  localparam int NTAPS = 5;
  localparam int XLEN  = 32;

  logic            clock;
  logic            reset;
  logic            io_valid;
  logic [31:0]     io_insn;
  logic [XLEN-1:0] io_rs1;
  logic [XLEN-1:0] io_rs2;
  logic [XLEN-1:0] io_rd;

  int checks = 0;
  int errors = 0;

  bit [31:0] mcoef [NTAPS];
  bit [31:0] mx    [NTAPS];
  bit [31:0] mrd;

  scie_pipelined #(.NTAPS(NTAPS), .XLEN(XLEN)) dut (
    .clock   (clock),
    .reset   (reset),
    .io_valid(io_valid),
    .io_insn (io_insn),
    .io_rs1  (io_rs1),
    .io_rs2  (io_rs2),
    .io_rd   (io_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       valid;
    logic [6:0] op;
    bit [31:0]  rs1;
    bit [31:0]  rs2;
    bit [31:0]  exp_rd;
  } vec_t;

  task automatic check(input string name, input bit [31:0] got, input bit [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d (0x%h) want %0d (0x%h)", name, got, got, want, want);
    end
  endtask

  // Reference: filter state as plain arrays, output = dot product of coef and samples.
  task automatic model_update(input logic r, input logic v, input logic [6:0] op,
                              input bit [31:0] a, input bit [31:0] b);
    bit [31:0] s;
    if (r) begin
      for (int i = 0; i < NTAPS; i++) begin
        mcoef[i] = 0;
        mx[i]    = 0;
      end
      mrd = 0;
    end else if (v) begin
      if (op == 7'h0B) begin
        if (b < NTAPS) mcoef[b[2:0]] = a;
      end else if (op == 7'h2B) begin
        for (int i = NTAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = a;
      end else if (op == 7'h5B) begin
        s = 0;
        for (int i = 0; i < NTAPS; i++) s = s + mcoef[i] * mx[i];
        mrd = s;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [6:0] op,
                      input bit [31:0] a, input bit [31:0] b);
    logic [31:0] w;
    @(negedge clock);
    w        = $urandom;
    w[6:0]   = op;
    reset    = r;
    io_valid = v;
    io_insn  = w;
    io_rs1   = a;
    io_rs2   = b;
    @(posedge clock);
    model_update(r, v, op, a, b);
    #1;
    check("model", io_rd, mrd);
  endtask

  task automatic load_coefs();
    step(0, 1, 7'h0B, 5, 0);
    step(0, 1, 7'h0B, 99, 1);
    step(0, 1, 7'h0B, 47, 2);
    step(0, 1, 7'h0B, 41, 3);
    step(0, 1, 7'h0B, 25, 4);
  endtask

  task automatic filter_run(input string tag);
    bit [31:0] xs [5];
    bit [31:0] ys [5];
    xs = '{90, 64, 93, 1, 97};
    ys = '{450, 9230, 11031, 15910, 9829};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 7'h2B, xs[i], 0);
      step(0, 0, 7'h00, 0, 0);
      step(0, 1, 7'h5B, 0, 0);
      check($sformatf("%s_y%0d", tag, i), io_rd, ys[i]);
    end
  endtask

  vec_t tbl [20];

  initial begin
    reset    = 1'b1;
    io_valid = 1'b0;
    io_insn  = '0;
    io_rs1   = '0;
    io_rs2   = '0;

    // Reset held for five cycles, then READ
    for (int i = 0; i < 5; i++) step(1, 0, 7'h00, 0, 0);
    check("reset_rd", io_rd, 0);
    step(0, 1, 7'h5B, 0, 0);
    check("read_after_reset", io_rd, 0);

    // Table: coefficient load then PUSH / idle / READ for each sample
    tbl[0] = '{1'b1, 7'h0B, 5,  0, 0};
    tbl[1] = '{1'b1, 7'h0B, 99, 1, 0};
    tbl[2] = '{1'b1, 7'h0B, 47, 2, 0};
    tbl[3] = '{1'b1, 7'h0B, 41, 3, 0};
    tbl[4] = '{1'b1, 7'h0B, 25, 4, 0};
    tbl[5]  = '{1'b1, 7'h2B, 90, 0, 0};
    tbl[6]  = '{1'b0, 7'h00, 0,  0, 0};
    tbl[7]  = '{1'b1, 7'h5B, 0,  0, 450};
    tbl[8]  = '{1'b1, 7'h2B, 64, 0, 450};
    tbl[9]  = '{1'b0, 7'h00, 0,  0, 450};
    tbl[10] = '{1'b1, 7'h5B, 0,  0, 9230};
    tbl[11] = '{1'b1, 7'h2B, 93, 0, 9230};
    tbl[12] = '{1'b0, 7'h00, 0,  0, 9230};
    tbl[13] = '{1'b1, 7'h5B, 0,  0, 11031};
    tbl[14] = '{1'b1, 7'h2B, 1,  0, 11031};
    tbl[15] = '{1'b0, 7'h00, 0,  0, 11031};
    tbl[16] = '{1'b1, 7'h5B, 0,  0, 15910};
    tbl[17] = '{1'b1, 7'h2B, 97, 0, 15910};
    tbl[18] = '{1'b0, 7'h00, 0,  0, 15910};
    tbl[19] = '{1'b1, 7'h5B, 0,  0, 9829};
    for (int i = 0; i < 20; i++) begin
      step(0, tbl[i].valid, tbl[i].op, tbl[i].rs1, tbl[i].rs2);
      check($sformatf("vec%0d", i), io_rd, tbl[i].exp_rd);
    end

    // Reset for one cycle after the sequence, then READ
    step(1, 1, 7'h2B, 77, 0);
    step(0, 1, 7'h5B, 0, 0);
    check("read_after_midreset", io_rd, 0);

    // Out-of-range coefficient index, including upper-bit-only index
    load_coefs();
    step(0, 1, 7'h0B, 1000, 5);
    step(0, 1, 7'h0B, 1000, 32'h8000_0000);
    step(0, 1, 7'h0B, 1000, 32'h0001_0002);
    filter_run("oor");

    // Valid gating: PUSH/READ encodings with valid low, unknown opcode with valid high
    step(0, 0, 7'h2B, 12345, 0);
    check("gated_push_hold", io_rd, 9829);
    step(0, 0, 7'h5B, 0, 0);
    check("gated_read_hold", io_rd, 9829);
    step(0, 1, 7'h7B, 555, 1);
    step(0, 1, 7'h5B, 0, 0);
    check("gated_state_same", io_rd, 9829);

    // Wrap-around modulo 2^32
    step(1, 0, 7'h00, 0, 0);
    step(0, 1, 7'h0B, 32'hFFFF_FFFF, 0);
    step(0, 1, 7'h2B, 2, 0);
    step(0, 1, 7'h5B, 0, 0);
    check("wrap", io_rd, 32'hFFFF_FFFE);

    // Back-to-back PUSH then READ sees the new sample
    step(1, 0, 7'h00, 0, 0);
    load_coefs();
    step(0, 1, 7'h2B, 90, 0);
    step(0, 1, 7'h2B, 64, 0);
    step(0, 1, 7'h5B, 0, 0);
    check("b2b_push_read", io_rd, 9230);

    // Reset wins over a simultaneous READ
    step(1, 1, 7'h5B, 0, 0);
    check("reset_priority", io_rd, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [6:0] op;
      bit [31:0]  b;
      case ($urandom_range(0, 5))
        0, 1:    op = 7'h0B;
        2, 3:    op = 7'h2B;
        4:       op = 7'h5B;
        default: op = ($urandom_range(0, 1) == 0) ? 7'h7B : 7'(($urandom));
      endcase
      b = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 6);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), op, $urandom, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
